// File: rtl/decoder_rr_scheduler_if.sv
// Select/enable/grant bundle between the requesters, decoder_rr_scheduler and the 3-to-8 decoder.
interface decoder_rr_scheduler_if;
  logic [7:0] req;
  logic       done;
  logic [2:0] dec_in;
  logic       dec_enable;
  logic [7:0] gnt;
  logic       busy;
  logic       timeout;

  modport master (
    input  req, done,
    output dec_in, dec_enable, gnt, busy, timeout
  );

  modport slave (
    output req, done,
    input  dec_in, dec_enable, gnt, busy, timeout
  );
endinterface

// File: rtl/decoder_rr_scheduler.sv
// Round-robin owner of a shared 3-to-8 decoder with a fixed turnaround gap after every release.
// Define ARB_TIMEOUT_EN to build the MAX_HOLD forced-release counter and the timeout pulse.
module decoder_rr_scheduler #(
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned MAX_HOLD   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  decoder_rr_scheduler_if.master        bus
);

  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  if (GAP_CYCLES < 1 || MAX_HOLD < 1) begin : g_bad_params
    $error("decoder_rr_scheduler: GAP_CYCLES and MAX_HOLD must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t        state_q, state_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [2:0]    dec_in_q, dec_in_d;
  logic          en_q, en_d;
  logic [7:0]    gnt_q, gnt_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;
  logic [GW-1:0] gap_q, gap_d;

  logic          win_valid;
  logic [2:0]    win_idx;
  logic          release_nat;
  logic          release_force;

  // First requester strictly after the last-served pointer, wrapping back to the pointer itself.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 1; k <= 8; k++) begin
      if (!win_valid && bus.req[3'(ptr_q + 3'(k))]) begin
        win_valid = 1'b1;
        win_idx   = 3'(ptr_q + 3'(k));
      end
    end
  end

  assign release_nat = bus.done || !bus.req[dec_in_q];

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);

  logic [HW-1:0] hold_q, hold_d;

  always_comb begin
    hold_d = '0;
    if (state_q == GRANT && state_d == GRANT)
      hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end

  assign release_force = (state_q == GRANT) && (hold_q >= HOLD_LAST);
`else
  assign release_force = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd7;
      gap_q     <= '0;
      dec_in_q  <= '0;
      en_q      <= 1'b0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gap_q     <= gap_d;
      dec_in_q  <= dec_in_d;
      en_q      <= en_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: if (win_valid) state_d = GRANT;
      GRANT: begin
        if (release_nat || release_force) begin
          state_d = GAP;
          ptr_d   = dec_in_q;
          gap_d   = '0;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = win_valid ? GRANT : IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are computed from the next state.
  always_comb begin
    dec_in_d  = dec_in_q;
    if (state_q != GRANT && state_d == GRANT) dec_in_d = win_idx;
    en_d      = (state_d == GRANT);
    gnt_d     = en_d ? (8'b1 << dec_in_d) : '0;
    busy_d    = (state_d != IDLE);
    timeout_d = (state_q == GRANT) && release_force && !release_nat;
  end

  assign bus.dec_in     = dec_in_q;
  assign bus.dec_enable = en_q;
  assign bus.gnt        = gnt_q;
  assign bus.busy       = busy_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_decoder_rr_scheduler.sv
// Self-checking bench for decoder_rr_scheduler: directed scenarios plus random req/done traffic
// compared each cycle against a transaction-level reference model.
module tb_decoder_rr_scheduler;
  localparam int unsigned GAP  = 1;
  localparam int unsigned HOLD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  decoder_rr_scheduler_if bus ();

  decoder_rr_scheduler #(.GAP_CYCLES(GAP), .MAX_HOLD(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the decoder, how long, and how many gap cycles remain.
  bit m_en;
  int m_sel, m_ptr, m_gap, m_hold;
  bit m_to;

  function automatic int rr_pick(input logic [7:0] r, input int ptr);
    logic [15:0] dbl;
    int          start;
    start = (ptr + 1) % 8;
    dbl   = {r, r} >> start;
    for (int i = 0; i < 8; i++)
      if (dbl[i]) return (start + i) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    m_en = 0; m_sel = 0; m_ptr = 7; m_gap = 0; m_hold = 0; m_to = 0;
  endtask

  task automatic model_step();
    bit rel, forced;
    int w;
    m_to = 0;
    if (m_en) begin
      m_hold++;
      rel = bus.done || !bus.req[m_sel];
`ifdef ARB_TIMEOUT_EN
      forced = (m_hold >= HOLD);
`else
      forced = 0;
`endif
      if (rel || forced) begin
        m_en  = 0;
        m_ptr = m_sel;
        m_gap = GAP;
        m_to  = !rel;
      end
    end else begin
      if (m_gap > 0) m_gap--;
      if (m_gap == 0) begin
        w = rr_pick(bus.req, m_ptr);
        if (w >= 0) begin
          m_en = 1; m_sel = w; m_hold = 0;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [7:0] exp_gnt;
    exp_gnt = m_en ? (8'b1 << m_sel) : 8'h00;
    check({tag, "/gnt"}, 32'(bus.gnt), 32'(exp_gnt));
    check({tag, "/sel_en_busy_to"},
          32'({bus.dec_in, bus.dec_enable, bus.busy, bus.timeout}),
          32'({3'(m_sel), m_en, (m_en || m_gap > 0), m_to}));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    compare_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "/gnt"}, 32'(bus.gnt), 32'h0);
    check({tag, "/en"},  32'(bus.dec_enable), 32'h0);
    check({tag, "/busy"}, 32'(bus.busy), 32'h0);
    model_reset();
    tick({tag, "_low"});
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[$];
    int to_seen;

    bus.req  = '0;
    bus.done = 1'b0;
    model_reset();
    repeat (3) tick("reset");
    rst_n = 1'b1;

    repeat (10) tick("t1_idle");

    bus.req = 8'h01;
    tick("t2_grant");
    check("t2_dec_in", 32'(bus.dec_in), 32'd0);
    bus.done = 1'b1; bus.req = 8'h00;
    tick("t2_release");
    bus.done = 1'b0;
    repeat (3) tick("t2_idle");

    bus.req = 8'h08;
    tick("t1b_grant");
    check("t1b_gnt", 32'(bus.gnt), 32'h08);
    tick("t1b_hold");
    async_reset("t1b_async");
    bus.req = 8'h00;
    tick("t1b_after");

    bus.req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      tick("t3_grant");
      order.push_back(int'(bus.dec_in));
      tick("t3_hold");
      bus.done = 1'b1;
      tick("t3_release");
      bus.done = 1'b0;
    end
    for (int g = 0; g < 9; g++) check("t3_order", 32'(order[g]), 32'(g % 8));
    bus.req = 8'h00;
    repeat (2) tick("t3_drain");

    bus.req = 8'h20;
    tick("t4_grant5");
    bus.req = 8'h21; bus.done = 1'b1;
    tick("t4_release5");
    bus.done = 1'b0;
    tick("t4_wrap");
    check("t4_first", 32'(bus.dec_in), 32'd0);
    bus.done = 1'b1;
    tick("t4_release0");
    bus.done = 1'b0;
    tick("t4_second_grant");
    check("t4_second", 32'(bus.dec_in), 32'd5);
    bus.req = 8'h00;
    repeat (2) tick("t4_drain");

    bus.req = 8'h08;
    tick("t5_grant3");
    bus.req = 8'h13;
    tick("t5_drop");
    check("t5_drop_gnt", 32'(bus.gnt), 32'h0);
    tick("t5_next_grant");
    check("t5_next", 32'(bus.dec_in), 32'd4);
    bus.req = 8'h00;
    repeat (2) tick("t5_drain");

    bus.req = 8'h04;
    to_seen = 0;
    repeat (100) begin
      tick("t6_hold");
      if (bus.timeout) to_seen++;
    end
`ifdef ARB_TIMEOUT_EN
    check("t6_timeouts", 32'(to_seen), 32'd20);
`else
    check("t6_timeouts", 32'(to_seen), 32'd0);
    check("t6_held", 32'(bus.gnt), 32'h04);
`endif
    bus.req = 8'h00;
    repeat (3) tick("t6_drain");

    repeat (600) begin
      if ($urandom_range(0, 3) == 0) bus.req = 8'($urandom);
      bus.done = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) async_reset("rnd_async");
      else                            tick("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
